// File: rtl/matmul_job_scheduler.sv
// matmul_job_scheduler
//   Arbitrates two requesters for one matrix-multiplication datapath. It
//   validates the winner's dimensions, programs the multiplier operation
//   registers, resets and enables the multiplier, and waits for its done
//   flag. It then returns a one-cycle completion pulse with a status code
//   to the owning requester.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   req[1:0]              : per-requester job request (held until cmp_valid)
//   req_n/m/p[15:0]       : two 8-bit dimension fields, [8r+7:8r] for requester r
//   gnt[1:0]              : one-hot current owner, 0 when free
//   cmp_valid[1:0]        : one-cycle completion pulse to the owner
//   cmp_status[1:0]       : 00 ok, 01 dimension error, 10 timeout
//   busy                  : FSM not in IDLE
//   mm_reset, mm_enable   : multiplier reset pulse / enable
//   op_n, op_m, op_p      : multiplier operation registers (zero-extended dims)
//   mm_done               : multiplier done flag
//
// All outputs come straight from flops loaded with values decoded from the
// next state, so each output is valid for exactly the cycle the FSM sits in
// the corresponding state.
module matmul_job_scheduler #(
    parameter int DIM_MAX  = 8,
    parameter int PAR_JOBS = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] req_n,
    input  logic [15:0] req_m,
    input  logic [15:0] req_p,
    output logic [1:0]  gnt,
    output logic [1:0]  cmp_valid,
    output logic [1:0]  cmp_status,
    output logic        busy,
    output logic        mm_reset,
    output logic        mm_enable,
    output logic [31:0] op_n,
    output logic [31:0] op_m,
    output logic [31:0] op_p,
    input  logic        mm_done
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DIM_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CLEAR, S_ARM, S_RUN, S_COMPLETE, S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;     // index of the granted requester
    logic             rr_q, rr_d;           // requester favored on a tie
    logic [7:0]       n_q, n_d, m_q, m_d, p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       status_q, status_d;

    logic [1:0]       gnt_d, cmp_valid_d, cmp_status_d;
    logic             busy_d, mm_reset_d, mm_enable_d;
    logic             winner;

    function automatic logic dim_ok(input logic [7:0] d);
        return (d != 8'd0) && (int'(d) <= DIM_MAX);
    endfunction

    function automatic logic job_ok(input logic [7:0] n, input logic [7:0] m,
                                    input logic [7:0] p);
        return dim_ok(n) && dim_ok(m) && dim_ok(p) && ((int'(n) % PAR_JOBS) == 0);
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            n_q      <= 8'd0;
            m_q      <= 8'd0;
            p_q      <= 8'd0;
            cnt_q    <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            n_q      <= n_d;
            m_q      <= m_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        n_d      = n_q;
        m_d      = m_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        // The favored requester wins when it is asking; otherwise the other one.
        winner   = req[rr_q] ? rr_q : ~rr_q;

        unique case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d = winner;
                    rr_d    = ~winner;
                    n_d     = winner ? req_n[15:8] : req_n[7:0];
                    m_d     = winner ? req_m[15:8] : req_m[7:0];
                    p_d     = winner ? req_p[15:8] : req_p[7:0];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (job_ok(n_q, m_q, p_q)) begin
                    status_d = ST_OK;
                    state_d  = S_CLEAR;
                end else begin
                    status_d = ST_DIM_ERR;
                    state_d  = S_COMPLETE;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_ARM;
            end
            S_ARM: begin
                // A done still high from the multiplier's reset is not a completion.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_COMPLETE;
                end else if (!mm_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mm_done) begin
                    status_d = ST_OK;
                    state_d  = S_COMPLETE;
                end else if (cnt_q == CNT_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_COMPLETE;
                end
            end
            S_COMPLETE: state_d = S_RELEASE;
            S_RELEASE:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        gnt_d        = 2'b00;
        cmp_valid_d  = 2'b00;
        cmp_status_d = ST_OK;
        mm_reset_d   = 1'b0;
        mm_enable_d  = 1'b0;

        unique case (state_d)
            S_CHECK, S_CLEAR, S_ARM, S_RUN: begin
                gnt_d = owner_d ? 2'b10 : 2'b01;
            end
            default: ;
        endcase

        if (state_d == S_CLEAR) mm_reset_d = 1'b1;
        if (state_d == S_ARM || state_d == S_RUN) mm_enable_d = 1'b1;

        if (state_d == S_COMPLETE) begin
            gnt_d        = owner_d ? 2'b10 : 2'b01;
            cmp_valid_d  = owner_d ? 2'b10 : 2'b01;
            cmp_status_d = status_d;
            // A timed-out multiplier is left mid-operation; reset it again.
            mm_reset_d   = (status_d == ST_TIMEOUT);
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt        <= 2'b00;
            cmp_valid  <= 2'b00;
            cmp_status <= ST_OK;
            busy       <= 1'b0;
            mm_reset   <= 1'b0;
            mm_enable  <= 1'b0;
        end else begin
            gnt        <= gnt_d;
            cmp_valid  <= cmp_valid_d;
            cmp_status <= cmp_status_d;
            busy       <= busy_d;
            mm_reset   <= mm_reset_d;
            mm_enable  <= mm_enable_d;
        end
    end

    assign op_n = {24'd0, n_q};
    assign op_m = {24'd0, m_q};
    assign op_p = {24'd0, p_q};

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Testbench for matmul_job_scheduler. Two instances: dut (long timeout,
// PAR_JOBS=2) for the functional scenarios and dut_to (TIMEOUT=16) for the
// timeout scenario. Expected completions are queued when a request is
// driven and popped when cmp_valid appears.
module tb_matmul_job_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, req_to;
    logic [15:0] req_n, req_m, req_p;
    logic        mm_done, mm_done_to;

    logic [1:0]  gnt, cmp_valid, cmp_status;
    logic        busy, mm_reset, mm_enable;
    logic [31:0] op_n, op_m, op_p;

    logic [1:0]  gnt_t, cmp_valid_t, cmp_status_t;
    logic        busy_t, mm_reset_t, mm_enable_t;
    logic [31:0] op_n_t, op_m_t, op_p_t;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] own;
        logic [1:0] st;
        logic [7:0] n;
        logic [7:0] m;
        logic [7:0] p;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    matmul_job_scheduler #(.DIM_MAX(8), .PAR_JOBS(2), .TIMEOUT(4096)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_n(req_n), .req_m(req_m), .req_p(req_p),
        .gnt(gnt), .cmp_valid(cmp_valid), .cmp_status(cmp_status),
        .busy(busy), .mm_reset(mm_reset), .mm_enable(mm_enable),
        .op_n(op_n), .op_m(op_m), .op_p(op_p), .mm_done(mm_done)
    );

    matmul_job_scheduler #(.DIM_MAX(8), .PAR_JOBS(2), .TIMEOUT(16)) dut_to (
        .clk(clk), .reset(reset), .req(req_to),
        .req_n(req_n), .req_m(req_m), .req_p(req_p),
        .gnt(gnt_t), .cmp_valid(cmp_valid_t), .cmp_status(cmp_status_t),
        .busy(busy_t), .mm_reset(mm_reset_t), .mm_enable(mm_enable_t),
        .op_n(op_n_t), .op_m(op_m_t), .op_p(op_p_t), .mm_done(mm_done_to)
    );

    // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 2'b00; req_to = 2'b00; mm_done = 1'b1; mm_done_to = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b11; req_to = 2'b01; mm_done = 1'b1; mm_done_to = 1'b1;
        req_n = 16'h0202; req_m = 16'h0202; req_p = 16'h0202;
        step();
        step();
        total++;
        if ({gnt, cmp_valid, cmp_status, busy, mm_reset, mm_enable} !== 9'd0) begin
            bad++;
            $display("FAIL reset_ctrl got gnt=%b cv=%b st=%b busy=%b rst=%b en=%b want all 0",
                     gnt, cmp_valid, cmp_status, busy, mm_reset, mm_enable);
        end
        total++;
        if (op_n !== 32'd0 || op_m !== 32'd0 || op_p !== 32'd0) begin
            bad++;
            $display("FAIL reset_ops got n=%0d m=%0d p=%0d want 0 0 0", op_n, op_m, op_p);
        end
        total++;
        if ({gnt_t, cmp_valid_t, cmp_status_t, busy_t, mm_reset_t, mm_enable_t} !== 9'd0 ||
            op_n_t !== 32'd0 || op_m_t !== 32'd0 || op_p_t !== 32'd0) begin
            bad++;
            $display("FAIL reset_to_inst got gnt=%b busy=%b en=%b want 0", gnt_t, busy_t, mm_enable_t);
        end
        reset = 1'b0; req = 2'b00; req_to = 2'b00;
    endtask

    task automatic test_single_valid();
        exp_t e;
        bit   seen = 0;
        req_n = 16'h0202; req_m = 16'h0202; req_p = 16'h0202;
        req = 2'b01; mm_done = 1'b1;
        sbq.push_back('{own: 2'b01, st: 2'b00, n: 8'd2, m: 8'd2, p: 8'd2});
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) begin
                total++;
                if (gnt !== 2'b01 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL single_gnt got gnt=%b busy=%b want gnt=01 busy=1", gnt, busy);
                end
                total++;
                if (op_n !== 32'd2 || op_m !== 32'd2 || op_p !== 32'd2) begin
                    bad++;
                    $display("FAIL single_ops got n=%0d m=%0d p=%0d want 2 2 2", op_n, op_m, op_p);
                end
            end
            if (k == 2) begin
                total++;
                if (mm_reset !== 1'b1 || mm_enable !== 1'b0) begin
                    bad++;
                    $display("FAIL single_mmreset got rst=%b en=%b want rst=1 en=0", mm_reset, mm_enable);
                end
            end
            if (k == 3) begin
                total++;
                if (mm_enable !== 1'b1 || mm_reset !== 1'b0) begin
                    bad++;
                    $display("FAIL single_enable got en=%b rst=%b want en=1 rst=0", mm_enable, mm_reset);
                end
            end
            if (cmp_valid !== 2'b00) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL single_cmp got unexpected cv=%b at cyc=%0d want none", cmp_valid, k);
                end else begin
                    e = sbq.pop_front();
                    if (k != 21 || cmp_valid !== e.own || cmp_status !== e.st) begin
                        bad++;
                        $display("FAIL single_cmp got cv=%b st=%b cyc=%0d want cv=%b st=%b cyc=21",
                                 cmp_valid, cmp_status, k, e.own, e.st);
                    end
                end
                seen = 1;
                req  = 2'b00;
            end
            if (k == 23) begin
                total++;
                if (gnt !== 2'b00 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL single_idle got gnt=%b busy=%b want 00 0", gnt, busy);
                end
            end
            mm_done = (k >= 4 && k < 20) ? 1'b0 : 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL single_timeout got no cmp_valid want cmp_valid at cyc 21");
        end
        req = 2'b00; mm_done = 1'b1;
    endtask

    task automatic test_dim_errors();
        logic [7:0] tn[3] = '{8'd2, 8'd2, 8'd3};
        logic [7:0] tm[3] = '{8'd0, 8'd2, 8'd2};
        logic [7:0] tp[3] = '{8'd2, 8'd9, 8'd2};
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            bit seen = 0;
            bit en_seen = 0;
            req_n = {8'd0, tn[c]}; req_m = {8'd0, tm[c]}; req_p = {8'd0, tp[c]};
            req = 2'b01; mm_done = 1'b1;
            sbq.push_back('{own: 2'b01, st: 2'b01, n: tn[c], m: tm[c], p: tp[c]});
            for (int k = 1; k <= 4; k++) begin
                step();
                if (mm_enable !== 1'b0) en_seen = 1;
                if (cmp_valid !== 2'b00) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL dimerr%0d_cmp got unexpected cv=%b want none", c, cmp_valid);
                    end else begin
                        e = sbq.pop_front();
                        if (k != 2 || cmp_valid !== e.own || cmp_status !== e.st ||
                            op_n !== {24'd0, e.n} || op_m !== {24'd0, e.m} || op_p !== {24'd0, e.p}) begin
                            bad++;
                            $display("FAIL dimerr%0d_cmp got cv=%b st=%b cyc=%0d n=%0d m=%0d p=%0d want cv=%b st=%b cyc=2 n=%0d m=%0d p=%0d",
                                     c, cmp_valid, cmp_status, k, op_n, op_m, op_p, e.own, e.st, e.n, e.m, e.p);
                        end
                    end
                    seen = 1;
                    req  = 2'b00;
                end
            end
            total++;
            if (en_seen || !seen) begin
                bad++;
                $display("FAIL dimerr%0d_flow got enable_seen=%0d cmp_seen=%0d want 0 1", c, en_seen, seen);
            end
            req = 2'b00;
        end
    endtask

    task automatic test_fairness();
        exp_t       e;
        logic [1:0] prev_gnt = 2'b00;
        logic [1:0] want;
        int         ec = 0;
        int         ncmp = 0;
        int         ng = 0;
        do_reset();
        req_n = {8'd4, 8'd2}; req_m = {8'd8, 8'd4}; req_p = {8'd1, 8'd6};
        req = 2'b11;
        sbq.push_back('{own: 2'b01, st: 2'b00, n: 8'd2, m: 8'd4, p: 8'd6});
        sbq.push_back('{own: 2'b10, st: 2'b00, n: 8'd4, m: 8'd8, p: 8'd1});
        sbq.push_back('{own: 2'b01, st: 2'b00, n: 8'd2, m: 8'd4, p: 8'd6});
        for (int k = 1; k <= 200; k++) begin
            step();
            if (gnt !== 2'b00 && prev_gnt === 2'b00) begin
                want = (ng % 2 == 0) ? 2'b01 : 2'b10;
                total++;
                if (gnt !== want) begin
                    bad++;
                    $display("FAIL fair_gnt%0d got gnt=%b want %b", ng, gnt, want);
                end
                ng++;
            end
            prev_gnt = gnt;
            if (cmp_valid !== 2'b00) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL fair_cmp got unexpected cv=%b want none", cmp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (cmp_valid !== e.own || cmp_status !== e.st ||
                        op_n !== {24'd0, e.n} || op_m !== {24'd0, e.m} || op_p !== {24'd0, e.p}) begin
                        bad++;
                        $display("FAIL fair_cmp%0d got cv=%b st=%b n=%0d m=%0d p=%0d want cv=%b st=%b n=%0d m=%0d p=%0d",
                                 ncmp, cmp_valid, cmp_status, op_n, op_m, op_p, e.own, e.st, e.n, e.m, e.p);
                    end
                end
                ncmp++;
                if (ncmp == 3) req = 2'b00;
            end
            // Multiplier model: done stays high briefly after enable, drops, then rises.
            if (mm_enable === 1'b1) ec++; else ec = 0;
            mm_done = (ec >= 2 && ec < 6) ? 1'b0 : 1'b1;
            if (ncmp == 3 && busy === 1'b0) break;
        end
        total++;
        if (ncmp != 3 || ng != 3) begin
            bad++;
            $display("FAIL fair_count got completions=%0d grants=%0d want 3 3", ncmp, ng);
        end
        req = 2'b00; mm_done = 1'b1;
    endtask

    task automatic test_stale_done();
        exp_t e;
        bit   seen = 0;
        req_n = 16'h0004; req_m = 16'h0003; req_p = 16'h0005;
        req = 2'b01; mm_done = 1'b1;
        sbq.push_back('{own: 2'b01, st: 2'b00, n: 8'd4, m: 8'd3, p: 8'd5});
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 7) begin
                total++;
                if (mm_enable !== 1'b1 || cmp_valid !== 2'b00) begin
                    bad++;
                    $display("FAIL stale_hold got en=%b cv=%b want en=1 cv=00", mm_enable, cmp_valid);
                end
            end
            if (cmp_valid !== 2'b00) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL stale_cmp got unexpected cv=%b want none", cmp_valid);
                end else begin
                    e = sbq.pop_front();
                    if (k != 11 || cmp_valid !== e.own || cmp_status !== e.st || op_p !== {24'd0, e.p}) begin
                        bad++;
                        $display("FAIL stale_cmp got cv=%b st=%b cyc=%0d want cv=%b st=%b cyc=11",
                                 cmp_valid, cmp_status, k, e.own, e.st);
                    end
                end
                seen = 1;
                req  = 2'b00;
            end
            mm_done = (k == 8 || k == 9) ? 1'b0 : 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stale_timeout got no cmp_valid want cmp_valid at cyc 11");
        end
        req = 2'b00; mm_done = 1'b1;
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   seen = 0;
        req_n = 16'h0002; req_m = 16'h0002; req_p = 16'h0002;
        req_to = 2'b01; mm_done_to = 1'b1;
        sbq.push_back('{own: 2'b01, st: 2'b10, n: 8'd2, m: 8'd2, p: 8'd2});
        for (int k = 1; k <= 23; k++) begin
            step();
            if (cmp_valid_t !== 2'b00) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL timeout_cmp got unexpected cv=%b want none", cmp_valid_t);
                end else begin
                    e = sbq.pop_front();
                    if (k != 19 || cmp_valid_t !== e.own || cmp_status_t !== e.st ||
                        mm_reset_t !== 1'b1 || mm_enable_t !== 1'b0 || op_n_t !== {24'd0, e.n}) begin
                        bad++;
                        $display("FAIL timeout_cmp got cv=%b st=%b rst=%b en=%b cyc=%0d want cv=%b st=%b rst=1 en=0 cyc=19",
                                 cmp_valid_t, cmp_status_t, mm_reset_t, mm_enable_t, k, e.own, e.st);
                    end
                end
                seen = 1;
                req_to = 2'b00;
            end
            if (k == 20) begin
                total++;
                if (gnt_t !== 2'b00 || busy_t !== 1'b1 || mm_reset_t !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_release got gnt=%b busy=%b rst=%b want 00 1 0", gnt_t, busy_t, mm_reset_t);
                end
            end
            if (k == 21) begin
                total++;
                if (gnt_t !== 2'b00 || busy_t !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_idle got gnt=%b busy=%b want 00 0", gnt_t, busy_t);
                end
            end
            mm_done_to = (k >= 4) ? 1'b0 : 1'b1;
        end
        total++;
        if (!seen || op_m_t !== 32'd2 || op_p_t !== 32'd2) begin
            bad++;
            $display("FAIL timeout_seen got cmp_seen=%0d m=%0d p=%0d want 1 2 2", seen, op_m_t, op_p_t);
        end
        req_to = 2'b00; mm_done_to = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        bit stray = 0;
        req_n = 16'h0002; req_m = 16'h0002; req_p = 16'h0002;
        req = 2'b01; mm_done = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 7) begin
                total++;
                if (mm_enable !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL midrst_run got en=%b busy=%b want 1 1", mm_enable, busy);
                end
                reset = 1'b1;
                req   = 2'b00;
            end else if (k == 8) begin
                total++;
                if ({gnt, cmp_valid, cmp_status, busy, mm_reset, mm_enable} !== 9'd0 ||
                    op_n !== 32'd0 || op_m !== 32'd0 || op_p !== 32'd0) begin
                    bad++;
                    $display("FAIL midrst_outputs got gnt=%b cv=%b st=%b busy=%b rst=%b en=%b n=%0d want all 0",
                             gnt, cmp_valid, cmp_status, busy, mm_reset, mm_enable, op_n);
                end
                reset = 1'b0;
            end else if (k > 8) begin
                if (cmp_valid !== 2'b00 || gnt !== 2'b00) stray = 1;
            end
            mm_done = (k >= 4 && k < 10) ? 1'b0 : 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL midrst_stray got cmp_valid or gnt after reset want none");
        end
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; req_to = 2'b00;
        req_n = 16'h0; req_m = 16'h0; req_p = 16'h0;
        mm_done = 1'b1; mm_done_to = 1'b1;
        test_reset();
        test_single_valid();
        test_dim_errors();
        test_fairness();
        test_stale_done();
        test_timeout();
        test_reset_mid_run();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_job_scheduler.md
# matmul_job_scheduler

Arbitrates two requesters (e.g. host bus port and DMA sequencer) for the single matrix-multiplication datapath. For the winning request, the block validates the dimensions and drives the multiplier's operation registers. It then resets and enables the multiplier, watches its `done` flag, and returns one completion pulse with a status code to the owning requester. It sits between the requester fabric and the multiplier; the multiplier's matrix memories are out of scope.

## Interface
- `DIM_MAX`, default 8: largest legal value of any dimension (multiplier array size).
- `PAR_JOBS`, default 1: rows processed per multiplier step; the row count must be a multiple of it.
- `TIMEOUT`, default 4096: maximum cycles from `mm_enable` rise to `mm_done` rise.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req` in 2: per-requester job request, held high until its `cmp_valid`.
- `req_n` in 16: two 8-bit fields, `[8r+7:8r]`: rows of C (outer i bound).
- `req_m` in 16: two 8-bit fields: inner dimension (k bound).
- `req_p` in 16: two 8-bit fields: columns of C (j bound).
- `gnt` out 2: one-hot current owner, 0 when free.
- `cmp_valid` out 2: one-cycle completion pulse to the owner.
- `cmp_status` out 2: valid with `cmp_valid`. 00 ok, 01 dimension error, 10 timeout.
- `busy` out 1: high in any state other than IDLE.
- `mm_reset` out 1: synchronous reset pulse to the multiplier.
- `mm_enable` out 1: multiplier enable.
- `op_n`, `op_m`, `op_p` out 32 each: drive multiplier operation registers 1, 2 and 4. Zero-extended from the 8-bit fields.
- `mm_done` in 1: multiplier done flag.

## Operation
- All outputs are registered, Moore-style, asserted during the cycle the FSM is in the named state.
- **IDLE**
  - If `req` != 0, pick a winner: round-robin, and the requester not served last wins a tie.
  - Latch its dims into `op_*`; go to CHECK.
- **CHECK**
  - `gnt` is asserted here.
  - The job is invalid if any of the following hold: any dim is 0; any dim > `DIM_MAX`; `n % PAR_JOBS` != 0.
  - Invalid: go to COMPLETE with status 01. Valid: go to CLEAR.
- **CLEAR**: `mm_reset`=1 for exactly one cycle; then go to ARM.
- **ARM**
  - `mm_enable`=1, timeout counter starts at 0.
  - Wait for `mm_done`==0, the multiplier leaving its reset-time done=1; then go to RUN.
- **RUN**: `mm_enable`=1; wait for `mm_done`==1, then go to COMPLETE with status 00.
- **Timeout**: the counter increments every cycle in ARM/RUN. When it reaches `TIMEOUT`-1 without completion, go to COMPLETE with status 10.
- **COMPLETE**
  - `cmp_valid[owner]`=1 for one cycle; `mm_enable`=0; `gnt` still held.
  - On timeout, `mm_reset`=1 in this cycle.
  - Next state is RELEASE.
- **RELEASE**: `gnt`=0, no arbitration, one cycle; then IDLE.
- **Requester rule**: drop `req` no later than the cycle after `cmp_valid`. A `req` still high in IDLE is a new job.
- `req` and dims are sampled only in IDLE. Changes while granted are ignored.
- `op_*` keep their last value until the next grant.
- **Reset values**: `gnt`=0, `cmp_valid`=0, `cmp_status`=00, `busy`=0, `mm_reset`=0, `mm_enable`=0, `op_*`=0. State is IDLE and round-robin pointer = requester 0 favored next.
- **Reset mid-job**: all of the above take effect the next cycle. No `cmp_valid` is issued for the aborted job.

## Timing
- Request high in IDLE at cycle t gives:
  - `gnt` at t+1;
  - `mm_reset` at t+2;
  - `mm_enable` from t+3.
- Dimension error: `cmp_valid` at t+2, `mm_enable` never asserted.
- Valid job: `cmp_valid` one cycle after `mm_done` is first seen high in RUN.
- Minimum spacing between consecutive grants: COMPLETE, RELEASE, IDLE. Next `gnt` comes 3 cycles after `cmp_valid`.
- A `mm_done` glitch to 1 during ARM is ignored. Only a 0-then-1 sequence completes the job.

## Test plan
- **Single valid job**: req0, n=m=p=2, with a multiplier model whose done goes low at t+4 and high at t+20. Expect `gnt`=01 at t+1, `mm_reset` at t+2, `op_n/m/p`=2, and `cmp_valid`=01 with status 00 at t+21.
- **Dimension errors**, each giving `cmp_status`=01 at t+2 with `mm_enable` never high:
  - m=0;
  - p=`DIM_MAX`+1;
  - n=3 with `PAR_JOBS`=2.
- **Fairness**: req=11 held continuously. Grants alternate 01, 10, 01. Each job completes with its own dims on `op_*`.
- **Timeout**: done stuck at 0 after going low, `TIMEOUT`=16. Expect `cmp_status`=10 with `mm_reset` pulse in the same cycle, then IDLE after RELEASE.
- **Stale done**: `mm_done` held at 1 through ARM for 5 cycles, then 0, then 1. Completion occurs only after the final rise.
- **Reset mid-run**: `reset` during RUN. Next cycle all outputs are at reset values, and no `cmp_valid` follows.
